// File: rtl/tri_bbox_setup.sv
// Triangle bounding-box setup: clamp y, compute bbox, drop off-screen, buffer in a FIFO.
// Optional backface culling is enabled by defining TRI_BACKFACE_CULL_EN.
module tri_bbox_setup #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned H_PIX = 1024,
   parameter int unsigned V_PIX = 768
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    valid_in,
   input  logic [31:0]             triangle_x,
   input  logic [31:0]             triangle_y,
   input  logic [31:0]             triangle_z,
   input  logic [23:0]             color,
   input  logic                    last_in,
   input  logic                    ready_in,
   output logic                    valid_out,
   output logic [31:0]             tri_x_out,
   output logic [31:0]             tri_y_out,
   output logic [31:0]             tri_z_out,
   output logic [23:0]             color_out,
   output logic [9:0]              bbox_xmin,
   output logic [9:0]              bbox_xmax,
   output logic [9:0]              bbox_ymin,
   output logic [9:0]              bbox_ymax,
   output logic                    last_out,
   output logic                    frame_done,
   output logic                    overflow,
`ifdef TRI_BACKFACE_CULL_EN
   output logic [15:0]             culled_cnt,
`endif
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned CW     = $clog2(H_PIX);
   localparam int unsigned EW     = 161;
   localparam logic [10:0] YLIM   = 11'(V_PIX);
   localparam logic [9:0]  YCLAMP = 10'(V_PIX - 1);

   function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
      logic [CW-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
      logic [CW-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   // ---------------- S1: unpack, clamp, bbox ----------------
   logic [CW-1:0] xr [3];
   logic [CW-1:0] yr [3];
   logic [CW-1:0] yc [3];
   logic          off_d;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         xr[i] = triangle_x[10*i +: CW];
         yr[i] = triangle_y[10*i +: CW];
         yc[i] = ({1'b0, yr[i]} >= YLIM) ? YCLAMP : yr[i];
      end
      off_d = ({1'b0, min3(yr[0], yr[1], yr[2])} >= YLIM);
   end

   logic        s1_valid_q, s1_last_q, s1_off_q;
   logic [31:0] s1_x_q, s1_y_q, s1_z_q;
   logic [23:0] s1_color_q;
   logic [9:0]  s1_xmin_q, s1_xmax_q, s1_ymin_q, s1_ymax_q;

`ifdef TRI_BACKFACE_CULL_EN
   logic signed [21:0] dx1, dy1, dx2, dy2, area_d, s1_area_q;

   always_comb begin
      dx1    = $signed({12'd0, xr[1]}) - $signed({12'd0, xr[0]});
      dy1    = $signed({12'd0, yr[1]}) - $signed({12'd0, yr[0]});
      dx2    = $signed({12'd0, xr[2]}) - $signed({12'd0, xr[0]});
      dy2    = $signed({12'd0, yr[2]}) - $signed({12'd0, yr[0]});
      area_d = dx1 * dy2 - dx2 * dy1;
   end

   always_ff @(posedge clk_in) s1_area_q <= area_d;
`endif

   always_ff @(posedge clk_in) begin
      s1_x_q     <= triangle_x;
      s1_y_q     <= {triangle_y[31:30], yc[2], yc[1], yc[0]};
      s1_z_q     <= triangle_z;
      s1_color_q <= color;
      s1_last_q  <= last_in;
      s1_off_q   <= off_d;
      s1_xmin_q  <= min3(xr[0], xr[1], xr[2]);
      s1_xmax_q  <= max3(xr[0], xr[1], xr[2]);
      s1_ymin_q  <= min3(yc[0], yc[1], yc[2]);
      s1_ymax_q  <= max3(yc[0], yc[1], yc[2]);
   end

   // ---------------- S2: drop decision ----------------
   logic          s2_keep, s2_valid_q;
   logic [EW-1:0] s2_entry_q;

`ifdef TRI_BACKFACE_CULL_EN
   logic        culled;
   logic [15:0] culled_cnt_q;

   always_comb begin
      s2_keep = s1_last_q | (~s1_off_q & (s1_area_q > 22'sd0));
      culled  = s1_valid_q & ~s1_last_q & ~s1_off_q & (s1_area_q <= 22'sd0);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         culled_cnt_q <= '0;
      end else if (culled && culled_cnt_q != 16'hFFFF) begin
         culled_cnt_q <= culled_cnt_q + 16'd1;
      end
   end

   assign culled_cnt = culled_cnt_q;
`else
   always_comb s2_keep = s1_last_q | ~s1_off_q;
`endif

   always_ff @(posedge clk_in) begin
      s2_entry_q <= {s1_last_q, s1_ymax_q, s1_ymin_q, s1_xmax_q, s1_xmin_q,
                     s1_color_q, s1_z_q, s1_y_q, s1_x_q};
   end

   // ---------------- FIFO ----------------
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d, frame_done_q;
   logic          full, rd_en, wr_en;
   logic [EW-1:0] head;

   always_comb begin
      full       = (count_q == (AW+1)'(DEPTH));
      valid_out  = (count_q != '0);
      rd_en      = valid_out & ready_in;
      // A full FIFO still accepts the write when the head leaves on the same edge.
      wr_en      = s2_valid_q & (~full | rd_en);
      overflow_d = overflow_q | (s2_valid_q & full & ~rd_en);
      count_d    = count_q;
      if (wr_en && !rd_en) begin
         count_d = count_q + 1'b1;
      end else if (!wr_en && rd_en) begin
         count_d = count_q - 1'b1;
      end
      head = valid_out ? mem_q[rd_ptr_q] : '0;
   end

   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= s2_entry_q;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_valid_q   <= 1'b0;
         s2_valid_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         s1_valid_q   <= valid_in;
         s2_valid_q   <= s1_valid_q & s2_keep;
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         frame_done_q <= rd_en & head[EW-1];
      end
   end

   assign {last_out, bbox_ymax, bbox_ymin, bbox_xmax, bbox_xmin,
           color_out, tri_z_out, tri_y_out, tri_x_out} = head;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tri_bbox_setup.sv
// Directed bench for tri_bbox_setup: vector table plus backpressure, overflow and reset sequences.
module tb_tri_bbox_setup;

   logic        clk_in = 1'b0;
   logic        rst_in, valid_in, last_in, ready_in;
   logic [31:0] triangle_x, triangle_y, triangle_z;
   logic [23:0] color;
   logic        valid_out, last_out, frame_done, overflow;
   logic [31:0] tri_x_out, tri_y_out, tri_z_out;
   logic [23:0] color_out;
   logic [9:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
   logic [3:0]  count;
`ifdef TRI_BACKFACE_CULL_EN
   logic [15:0] culled_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   tri_bbox_setup #(.DEPTH(8), .H_PIX(1024), .V_PIX(768)) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .valid_in   (valid_in),
      .triangle_x (triangle_x),
      .triangle_y (triangle_y),
      .triangle_z (triangle_z),
      .color      (color),
      .last_in    (last_in),
      .ready_in   (ready_in),
      .valid_out  (valid_out),
      .tri_x_out  (tri_x_out),
      .tri_y_out  (tri_y_out),
      .tri_z_out  (tri_z_out),
      .color_out  (color_out),
      .bbox_xmin  (bbox_xmin),
      .bbox_xmax  (bbox_xmax),
      .bbox_ymin  (bbox_ymin),
      .bbox_ymax  (bbox_ymax),
      .last_out   (last_out),
      .frame_done (frame_done),
      .overflow   (overflow),
`ifdef TRI_BACKFACE_CULL_EN
      .culled_cnt (culled_cnt),
`endif
      .count      (count)
   );

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        last;
      logic        emit;
      logic [9:0]  xmin, xmax, ymin, ymax;
      logic [31:0] y_out;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [31:0] pk(input logic [9:0] v2, input logic [9:0] v1,
                                      input logic [9:0] v0);
      return {2'b00, v2, v1, v0};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      tick();
   endtask

   task automatic push_tri(input logic [31:0] x, input logic [31:0] y, input logic last);
      valid_in   = 1'b1;
      triangle_x = x;
      triangle_y = y;
      triangle_z = x ^ y;
      color      = {8'hA5, x[7:0], y[7:0]};
      last_in    = last;
      tick();
      valid_in   = 1'b0;
      last_in    = 1'b0;
   endtask

   // Counter-clockwise right triangle with xmin = k, xmax = k + 10.
   task automatic push_ccw(input logic [9:0] k);
      push_tri(pk(k, k + 10'd10, k), pk(10'd10, 10'd0, 10'd0), 1'b0);
   endtask

   task automatic apply_vec(input string n, input vec_t v);
      push_tri(v.x, v.y, v.last);
      tick();
      chk({n, "_early"}, 64'(valid_out), 64'd0);
      tick();
      chk({n, "_valid"}, 64'(valid_out), 64'(v.emit));
      if (v.emit) begin
         chk({n, "_xmin"}, 64'(bbox_xmin), 64'(v.xmin));
         chk({n, "_xmax"}, 64'(bbox_xmax), 64'(v.xmax));
         chk({n, "_ymin"}, 64'(bbox_ymin), 64'(v.ymin));
         chk({n, "_ymax"}, 64'(bbox_ymax), 64'(v.ymax));
         chk({n, "_yout"}, 64'(tri_y_out), 64'(v.y_out));
         chk({n, "_xout"}, 64'(tri_x_out), 64'(v.x));
         chk({n, "_zout"}, 64'(tri_z_out), 64'(v.x ^ v.y));
         chk({n, "_color"}, 64'(color_out), 64'({8'hA5, v.x[7:0], v.y[7:0]}));
         chk({n, "_last"}, 64'(last_out), 64'(v.last));
      end
      chk({n, "_fd_pre"}, 64'(frame_done), 64'd0);
      tick();
      chk({n, "_fd"}, 64'(frame_done), 64'(v.last & v.emit));
      chk({n, "_drained"}, 64'(valid_out), 64'd0);
      tick();
      chk({n, "_fd_post"}, 64'(frame_done), 64'd0);
   endtask

   initial begin
      vec_t cv;
      rst_in = 1'b1; valid_in = 1'b0; last_in = 1'b0; ready_in = 1'b0;
      triangle_x = '0; triangle_y = '0; triangle_z = '0; color = '0;

      vecs[0] = '{pk(30, 20, 10), pk(50, 5, 40), 1'b0, 1'b1, 10'd10, 10'd30, 10'd5, 10'd50,
                  pk(50, 5, 40)};
      vecs[1] = '{pk(30, 20, 10), pk(900, 10, 10), 1'b0, 1'b1, 10'd10, 10'd30, 10'd10, 10'd767,
                  pk(767, 10, 10)};
      vecs[2] = '{pk(30, 20, 10), pk(800, 780, 768), 1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 10'd0,
                  32'd0};
      vecs[3] = '{pk(30, 20, 10), pk(800, 780, 768), 1'b1, 1'b1, 10'd10, 10'd30, 10'd767,
                  10'd767, pk(767, 767, 767)};
      vecs[4] = '{pk(0, 1023, 512), pk(767, 0, 100), 1'b0, 1'b1, 10'd0, 10'd1023, 10'd0,
                  10'd767, pk(767, 0, 100)};
      vecs[5] = '{pk(100, 50, 0), pk(768, 0, 0), 1'b0, 1'b1, 10'd0, 10'd100, 10'd0, 10'd767,
                  pk(767, 0, 0)};

      tick();
      chk("rst_valid", 64'(valid_out), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_bbox_xmax", 64'(bbox_xmax), 64'd0);
      chk("rst_tri_x", 64'(tri_x_out), 64'd0);
      rst_in = 1'b0;
      tick();

      ready_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         apply_vec($sformatf("v%0d", i), vecs[i]);
      end

      cv = '{pk(0, 10, 0), pk(10, 0, 0), 1'b0, 1'b1, 10'd0, 10'd10, 10'd0, 10'd10,
             pk(10, 0, 0)};
      apply_vec("ccw", cv);
      cv.x = pk(10, 0, 0); cv.y = pk(0, 10, 0); cv.y_out = pk(0, 10, 0);
`ifdef TRI_BACKFACE_CULL_EN
      chk("cull_cnt0", 64'(culled_cnt), 64'd0);
      cv.emit = 1'b0;
      apply_vec("cw", cv);
      chk("cull_cnt1", 64'(culled_cnt), 64'd1);
      cv.x = pk(10, 5, 0); cv.y = pk(10, 5, 0);
      apply_vec("collinear", cv);
      chk("cull_cnt2", 64'(culled_cnt), 64'd2);
`else
      apply_vec("cw_pass", cv);
`endif

      // Backpressure: fill, overflow, then drain in order.
      do_reset();
      ready_in = 1'b0;
      for (int i = 0; i < 8; i++) push_ccw(10'(i + 1));
      tick(); tick();
      chk("bp_count8", 64'(count), 64'd8);
      chk("bp_no_ovf", 64'(overflow), 64'd0);
      chk("bp_head", 64'(bbox_xmin), 64'd1);
      push_ccw(10'd40);
      tick(); tick();
      chk("bp_ovf", 64'(overflow), 64'd1);
      chk("bp_count_hold", 64'(count), 64'd8);
      chk("bp_head_stable", 64'(bbox_xmin), 64'd1);
      chk("bp_xmax_stable", 64'(bbox_xmax), 64'd11);
      ready_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("bp_out%0d_valid", i), 64'(valid_out), 64'd1);
         chk($sformatf("bp_out%0d_xmin", i), 64'(bbox_xmin), 64'(i + 1));
         tick();
      end
      chk("bp_ninth_absent", 64'(valid_out), 64'd0);
      chk("bp_ovf_sticky", 64'(overflow), 64'd1);

      // Asynchronous reset with entries buffered and overflow set.
      ready_in = 1'b0;
      for (int i = 0; i < 5; i++) push_ccw(10'(i + 20));
      tick(); tick();
      chk("mid_count5", 64'(count), 64'd5);
      #2 rst_in = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(valid_out), 64'd0);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_ovf", 64'(overflow), 64'd0);
      tick();
      rst_in = 1'b0;
      tick();

      // Write arrives on the same edge the full FIFO pops its head.
      for (int i = 0; i < 8; i++) push_ccw(10'(i + 1));
      push_ccw(10'd50);
      tick();
      chk("rw_count_full", 64'(count), 64'd8);
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      chk("rw_count_same", 64'(count), 64'd8);
      chk("rw_no_ovf", 64'(overflow), 64'd0);
      ready_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("rw_out%0d", i), 64'(bbox_xmin), 64'((i < 7) ? i + 2 : 50));
         tick();
      end
      chk("rw_empty", 64'(valid_out), 64'd0);
      chk("rw_count0", 64'(count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tri_bbox_setup.md
Name: tri_bbox_setup

Overview:
- Consumes the triangle stream produced by the triangle generator: one triangle per valid_in cycle, no backpressure upstream.
- Computes each triangle's screen bounding box, clamps it to the visible area and drops fully off-screen triangles.
- Buffers results in a FIFO and presents them to the rasterizer over a valid/ready handshake.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 4.
- H_PIX, 1024: visible width in pixels; x coordinates are 10 bits.
- V_PIX, 768: visible height; y values >= V_PIX are clamped to V_PIX-1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous reset, active-high
- valid_in  input  1  triangle present this cycle
- triangle_x  input  32  vertex x: v0 [9:0], v1 [19:10], v2 [29:20]; [31:30] ignored
- triangle_y  input  32  vertex y, same packing
- triangle_z  input  32  vertex z, same packing; passed through untouched
- color  input  24  RGB888 color
- last_in  input  1  final triangle of the frame
- ready_in  input  1  rasterizer can accept
- valid_out  output  1  FIFO head valid
- tri_x_out / tri_y_out / tri_z_out  output  32 each  packed vertices; y fields clamped
- color_out  output  24  color
- bbox_xmin, bbox_xmax  output  10 each  bounding box x
- bbox_ymin, bbox_ymax  output  10 each  bounding box y, clamped
- last_out  output  1  last-of-frame flag
- frame_done  output  1  one-cycle pulse when the last_out entry handshakes
- overflow  output  1  sticky: a triangle was lost because the FIFO was full
- count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, asynchronous: all outputs 0, FIFO empty, count=0, pipeline valids cleared, overflow cleared. Reset mid-stream discards all in-flight and buffered triangles.
- Stage S1, registered: latch inputs. Per y field, clamp to min(y, V_PIX-1). Compute xmin, xmax, ymin, ymax from the three vertices; ymin and ymax use clamped values. Unsigned 10-bit compares.
- Stage S2, registered: drop decision, then FIFO write.
  - Off-screen: drop if the raw (unclamped) minimum y >= V_PIX.
  - A triangle with last_in=1 is never dropped.
- FIFO write: a surviving S2 triangle writes one entry {x, y_clamped, z, color, bbox, last}.
- Full FIFO with no read this cycle: the entry is discarded and overflow is set to 1 until reset.
- Simultaneous read and write while full: the write is accepted; count is unchanged.
- Output: FIFO head is driven combinationally from registered storage. valid_out = (count != 0).
  - A transfer occurs on valid_out && ready_in; head advances next cycle.
  - Output data must hold stable while valid_out=1 and ready_in=0.
- Latency: valid_in at edge N gives valid_out high after edge N+2, provided the FIFO was empty and the triangle is not dropped.
- Throughput: one triangle per cycle in and out.
- frame_done: asserted one cycle after the edge on which an entry with last_out=1 transfers.
- Pointers wrap modulo DEPTH.
- count is updated every cycle: +1 on write only, -1 on read only, unchanged on both or neither.

Optional Feature:
- Macro TRI_BACKFACE_CULL_EN.
- Defined:
  - S1 additionally computes signed 2x area A = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), using 22-bit signed arithmetic on raw coords.
  - S2 drops the triangle if A <= 0 (clockwise or degenerate), unless last_in=1.
  - Adds output culled_cnt, 16 bits, saturating count of backface drops, reset to 0.
- Not defined: no area logic, no culled_cnt port; all on-screen triangles pass.

Test Plan:
- Reset defaults: after reset, hold ready_in=1, pulse valid_in with x={10'd30,10'd20,10'd10}, y={10'd50,10'd5,10'd40}, last_in=0 -> valid_out high two cycles after input; bbox_xmin=10, bbox_xmax=30, bbox_ymin=5, bbox_ymax=50; frame_done stays 0.
- Clamp and drop:
  - y={10'd900,10'd10,10'd10} -> bbox_ymax=767 and y field v2=767.
  - All y>=768 with last_in=0 -> no output; same triangle with last_in=1 -> emitted, frame_done pulses once on its handshake.
- Backpressure: ready_in=0, push 8 triangles -> count=8, overflow=0; push a 9th -> overflow=1, count stays 8; raise ready_in -> first 8 emerge in order, 9th absent.
- Full with simultaneous read/write: count=8, ready_in=1 and valid_in=1 same cycle -> count stays 8, overflow stays 0, new triangle appears in order.
- Reset mid-stream: rst_in asserted with 5 entries buffered -> valid_out=0, count=0, overflow=0 immediately, without waiting for a clock edge.
- Backface cull (TRI_BACKFACE_CULL_EN defined): counter-clockwise triangle v0=(0,0), v1=(10,0), v2=(0,10) -> A=100, emitted; swap v1 and v2 -> dropped, culled_cnt=1; collinear vertices -> dropped, culled_cnt=2.
